alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational datapath ALU.
- Operand width is generic. Adds arithmetic shift, signed/unsigned compare, status flags and an iterative shift-add multiplier (MUL) that takes WIDTH cycles.
- Sits between the decode/register-read stage and writeback. A valid/ready handshake on input and output lets the multi-cycle MUL stall the pipeline cleanly.

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus an iterative
// shift-add multiplier that holds the pipeline for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SHW:0]     cnt_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = A - B;
    assign shamt  = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_c   = (A >= B);
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(A) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: alu_res = '0;
        endcase
    end

    // One shift-add step per BUSY cycle; the last step's sum is the product.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (ALUControl == OP_MUL) begin
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= CNT_INIT;
                            state_q  <= S_BUSY;
                        end else begin
                            res_q   <= alu_res;
                            carry_q <= alu_c;
                            ovf_q   <= alu_v;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        res_q   <= acc_d;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign Zero      = (res_q == '0);
    assign Negative  = res_q[WIDTH-1];
    assign Carry     = carry_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): vector table for single-cycle ops,
// hand sequences for MUL latency, backpressure and reset mid-MUL.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Negative;
    logic        Carry;
    logic        Overflow;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            passed++;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({name, " ready timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        wait_ready(nm);
        A = v.a; B = v.b; ALUControl = v.op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALUControl = 4'b0000;
        check({nm, " out_valid"}, 32'(out_valid), 32'd1);
        check({nm, " result"},    ALUResult,       v.res);
        check({nm, " zero"},      32'(Zero),       32'(v.z));
        check({nm, " negative"},  32'(Negative),   32'(v.n));
        check({nm, " carry"},     32'(Carry),      32'(v.c));
        check({nm, " overflow"},  32'(Overflow),   32'(v.v));
        @(posedge clk); #1;
        check({nm, " back idle"}, 32'(in_ready),   32'd1);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat = 0;
        int bad_ready = 0;
        @(negedge clk);
        wait_ready("mul");
        A = a; B = b; ALUControl = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 32'h0; B = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) bad_ready++;
        end
        check("mul latency",        32'(lat),       32'd32);
        check("mul ready low busy", 32'(bad_ready), 32'd0);
        check("mul in_ready done",  32'(in_ready),  32'd0);
        check("mul result",         ALUResult,      exp);
        check("mul zero",           32'(Zero),      32'(exp == 32'h0));
        check("mul carry",          32'(Carry),     32'd0);
        @(posedge clk); #1;
        check("mul back idle",      32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //            a              b              op       res            z     n     c     v
        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 4'b0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{32'h0000_0003, 32'h0000_0005, 4'b0001, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 4'b0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0010, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0F00_0000, 32'h0000_00F0, 4'b0011, 32'h0F00_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFF_0000, 32'hFF00_FF00, 4'b0100, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0001, 32'h0000_0021, 4'b0101, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0000, 32'h0000_0024, 4'b0110, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0024, 4'b0111, 32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b1000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_0005, 32'h0000_0005, 4'b1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h0000_0005, 32'h0000_0005, 4'b0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{32'h0000_0001, 32'h0000_001F, 4'b0101, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUControl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result",    ALUResult,      32'h0);
        check("reset zero",      32'(Zero),      32'd1);
        check("reset flags",     {28'h0, Negative, Carry, Overflow, 1'b0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        run_mul(32'd12345, 32'd678, 32'd8369910);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

        // Backpressure: result must hold while out_ready is low, new input ignored.
        @(negedge clk);
        wait_ready("bp");
        out_ready = 1'b0;
        A = 32'd2; B = 32'd3; ALUControl = 4'b0000; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 32'd100; B = 32'd200; ALUControl = 4'b0001;
        begin
            int bad = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || ALUResult !== 32'd5 || Zero || Carry || Overflow) bad++;
            end
            check("bp hold cycles", 32'(bad), 32'd0);
        end
        check("bp result", ALUResult, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        check("bp idle hold result",  ALUResult,      32'd5);

        // Reset mid-MUL.
        @(negedge clk);
        A = 32'd12345; B = 32'd678; ALUControl = 4'b1010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midmul busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst mid out_valid", 32'(out_valid), 32'd1 - 32'd1);
        check("rst mid in_ready",  32'(in_ready),  32'd1);
        check("rst mid result",    ALUResult,      32'h0);
        check("rst mid zero",      32'(Zero),      32'd1);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t v;
            v = '{32'd2, 32'd2, 4'b0000, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0};
            run_vec(99, v);
        end
        repeat (40) @(posedge clk);
        #1;
        check("post abort quiet", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
